serial_packet_receiver: RTL and testbench

- Deserializer for the single-wire packet protocol: the receive end of the link whose transmitter sends a high start bit followed by 40 data bits, MSB first, one bit per clk.
- Detects start bits, shifts in 40 bits and checks a low stop cycle.
- Completed packets go into a small output FIFO with a valid/ready handshake.
- Sits between the serial input pin and the command decoder; reports framing errors and overruns.

---
 rtl/serial_packet_receiver.sv | 120 ++++++++++++
 tb/tb_serial_packet_receiver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_receiver.sv
// Serial packet receiver: detects a high start bit, shifts in DATA_BITS
// payload bits MSB first, checks a low stop cycle and queues completed
// packets in a small FIFO drained through a valid/ready handshake.
module serial_packet_receiver #(
  parameter int DATA_BITS  = 40,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 good_stop, bad_stop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wptr, rptr, wptr_n, rptr_n;
  logic                 empty, full, push, pop, drop;
  logic [DATA_BITS-1:0] head_n;

  // Receive FSM: next state, shift/count update and stop-cycle classification
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      IDLE: begin
        if (sin) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        shreg_n = {shreg[DATA_BITS-2:0], sin};
        cnt_n   = cnt + 1'b1;
        if (cnt == CW'(DATA_BITS - 1)) state_n = STOP;
      end
      STOP: begin
        // A high stop cycle is an error, never a start bit.
        state_n = IDLE;
        if (sin) bad_stop = 1'b1;
        else     good_stop = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO control: push on good stop (dropped only if full with no pop),
  // and the next registered head value
  always_comb begin
    empty  = (wptr == rptr);
    full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop    = !empty && out_ready;
    push   = good_stop && (!full || pop);
    drop   = good_stop && full && !pop;
    wptr_n = wptr + (AW+1)'(push);
    rptr_n = rptr + (AW+1)'(pop);
    if (wptr_n == rptr_n) begin
      // Empty after this edge: hold the last delivered packet.
      head_n = out_data;
    end else if (push && (rptr_n[AW-1:0] == wptr[AW-1:0])) begin
      // The new head is the slot being written this edge.
      head_n = shreg;
    end else begin
      head_n = mem[rptr_n[AW-1:0]];
    end
  end

  assign out_valid = (wptr != rptr);

  // Control and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      out_data    <= '0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      out_data    <= head_n;
      busy        <= (state_n != IDLE);
      frame_error <= bad_stop;
      overrun     <= drop;
    end
  end

  // Packet storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= shreg;
  end

endmodule

// File: tb/tb_serial_packet_receiver.sv
// Testbench for serial_packet_receiver: drives serial packets, keeps a
// packet-level reference model and compares all outputs every cycle.
module tb_serial_packet_receiver;

  localparam int DB    = 40;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sin = 1'b0;
  logic          out_ready = 1'b0;
  logic [DB-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          frame_error;
  logic          overrun;

  serial_packet_receiver #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Events the driver announces for the upcoming clock edge
  logic          ev_start = 1'b0, ev_good = 1'b0, ev_bad = 1'b0;
  logic [DB-1:0] ev_data = '0;
  bit            ready_level = 1'b0, rnd_ready = 1'b0;

  // Reference model state
  logic [DB-1:0] mq[$];
  logic [DB-1:0] m_last = '0;
  bit            m_busy = 1'b0;
  bit            exp_fe, exp_ov;

  // Observed DUT behaviour
  logic [DB-1:0] got[$];
  int            fe_cnt = 0, ov_cnt = 0, vcount = 0, first_valid = -1;
  logic          prev_valid = 1'b0;
  logic [DB-1:0] prev_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DB-1:0] got_at(input int i);
    if (got.size() > i) return got[i];
    return {DB{1'b1}};
  endfunction

  // Model update and comparison, 1 time unit after every rising edge
  initial begin
    int  n0;
    bit  pop;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        mq.delete();
        m_last = '0;
        m_busy = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
      end else begin
        n0     = mq.size();
        pop    = (n0 != 0) && out_ready;
        exp_fe = ev_bad;
        exp_ov = 1'b0;
        if (pop) void'(mq.pop_front());
        if (ev_good) begin
          if (n0 == DEPTH && !pop) exp_ov = 1'b1;
          else mq.push_back(ev_data);
        end
        if (ev_start) m_busy = 1'b1;
        if (ev_good || ev_bad) m_busy = 1'b0;
        if (mq.size() != 0) m_last = mq[0];
        // A pop happened at this edge if the DUT was offering data and ready was high.
        if (prev_valid && out_ready) got.push_back(prev_data);
      end
      chk("out_valid", out_valid, mq.size() != 0);
      chk("out_data", out_data, m_last);
      chk("busy", busy, m_busy);
      chk("frame_error", frame_error, exp_fe);
      chk("overrun", overrun, exp_ov);
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (out_valid) vcount++;
      if (out_valid && !prev_valid && first_valid < 0) first_valid = cyc + 1;
      prev_valid = out_valid;
      prev_data  = out_data;
    end
  end

  task automatic drive(input logic s);
    @(negedge clk);
    ev_start  = 1'b0;
    ev_good   = 1'b0;
    ev_bad    = 1'b0;
    sin       = s;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_level;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  task automatic send_pkt(input logic [DB-1:0] d, input bit bad, input bit pulse,
                          output int t_start);
    drive(1'b1);
    ev_start = 1'b1;
    t_start  = cyc + 1;
    for (int i = DB - 1; i >= 0; i--) drive(d[i]);
    drive(bad);
    ev_good = !bad;
    ev_bad  = bad;
    ev_data = d;
    if (pulse) out_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            t;
    logic [DB-1:0] d;
    // Reset with the line toggling
    rst_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sin = ~sin;
    end
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_data", out_data, 0);
    drive(1'b0);
    rst_n = 1'b1;
    idle(20);
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Single packet and its latency
    ready_level = 1'b1;
    got.delete(); first_valid = -1; vcount = 0;
    send_pkt(40'hD999999991, 1'b0, 1'b0, t);
    idle(5);
    chk("single_latency", first_valid - t, 42);
    chk("single_vcount", vcount, 1);
    chk("single_count", got.size(), 1);
    chk("single_data", got_at(0), 40'hD999999991);

    // Back-to-back packets
    got.delete(); fe_cnt = 0;
    send_pkt(40'h0700000000, 1'b0, 1'b0, t);
    send_pkt(40'hD999999993, 1'b0, 1'b0, t);
    idle(5);
    chk("b2b_count", got.size(), 2);
    chk("b2b_first", got_at(0), 40'h0700000000);
    chk("b2b_second", got_at(1), 40'hD999999993);
    chk("b2b_fe", fe_cnt, 0);

    // Framing error followed immediately by a good packet
    got.delete(); fe_cnt = 0;
    send_pkt(40'hD999999997, 1'b1, 1'b0, t);
    send_pkt(40'h0123456789, 1'b0, 1'b0, t);
    idle(5);
    chk("fe_count", fe_cnt, 1);
    chk("fe_pkts", got.size(), 1);
    chk("fe_next", got_at(0), 40'h0123456789);

    // Overrun: third packet dropped
    ready_level = 1'b0;
    idle(1);
    got.delete(); ov_cnt = 0;
    send_pkt(40'h1, 1'b0, 1'b0, t);
    send_pkt(40'h2, 1'b0, 1'b0, t);
    send_pkt(40'h3, 1'b0, 1'b0, t);
    idle(3);
    chk("ovr_count", ov_cnt, 1);
    ready_level = 1'b1;
    idle(6);
    chk("ovr_pkts", got.size(), 2);
    chk("ovr_a", got_at(0), 40'h1);
    chk("ovr_b", got_at(1), 40'h2);

    // Full FIFO with a pop in the same cycle as the push
    ready_level = 1'b0;
    idle(1);
    got.delete(); ov_cnt = 0;
    send_pkt(40'h1, 1'b0, 1'b0, t);
    send_pkt(40'h2, 1'b0, 1'b0, t);
    send_pkt(40'h3, 1'b0, 1'b1, t);
    idle(3);
    chk("pp_ovr", ov_cnt, 0);
    ready_level = 1'b1;
    idle(6);
    chk("pp_pkts", got.size(), 3);
    chk("pp_a", got_at(0), 40'h1);
    chk("pp_b", got_at(1), 40'h2);
    chk("pp_c", got_at(2), 40'h3);

    // Randomized traffic with random backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0:       d = '0;
        1:       d = '1;
        default: d = {8'($urandom), $urandom};
      endcase
      send_pkt(d, ($urandom_range(0, 7) == 0), 1'b0, t);
      idle($urandom_range(0, 3));
    end
    rnd_ready = 1'b0;
    ready_level = 1'b1;
    idle(10);

    // Asynchronous reset in the middle of a packet with data queued
    ready_level = 1'b0;
    send_pkt(40'hA5A5A5A5A5, 1'b0, 1'b0, t);
    idle(2);
    drive(1'b1);
    ev_start = 1'b1;
    repeat (5) drive(1'($urandom_range(0, 1)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_valid", out_valid, 1'b0);
    chk("async_data", out_data, 0);
    idle(2);
    rst_n = 1'b1;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
